// File: rtl/spectrum_bar_drawer.sv
// Per-bin FFT magnitude capture into a bar-height table, rendered as a bar graph on the raster.
// One bin every 3+RD_LAT cycles; pixel_data lags pixel_xpos/ypos by one cycle; no backpressure.
module spectrum_bar_drawer #(
  parameter int          N_BINS    = 128,
  parameter int          RD_LAT    = 2,
  parameter int          MAG_SHIFT = 6,
  parameter int          MAX_H     = 400,
  parameter int          BAR_W     = 8,
  parameter int          Y_BASE    = 719,
  parameter logic [23:0] BAR_COLOR = 24'h00FF00,
  parameter logic [23:0] BG_COLOR  = 24'h000000
) (
  input  logic        lcd_clk,
  input  logic        rst,
  input  logic        frame_start,
  output logic        data_req,
  input  logic [31:0] fifo_rd_data,
  output logic        wr_over,
  input  logic [10:0] pixel_xpos,
  input  logic [10:0] pixel_ypos,
  output logic [23:0] pixel_data,
  output logic        sweep_busy
);

  localparam int BW  = $clog2(N_BINS);
  localparam int LW  = $clog2(RD_LAT + 1);
  localparam int XSH = $clog2(BAR_W);

  localparam logic [BW-1:0] LAST_BIN = BW'(N_BINS - 1);
  localparam logic [LW-1:0] LAT_LAST = LW'(RD_LAT - 1);
  localparam logic [15:0]   MAX_H16  = 16'(MAX_H);
  localparam logic [11:0]   Y_BASE12 = 12'(Y_BASE);
  localparam logic [10:0]   N_BINS11 = 11'(N_BINS);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_CALC = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]    state;
  logic [LW-1:0] lat_cnt;
  logic [BW-1:0] bin_idx;
  logic [31:0]   sample;
  logic [8:0]    height [N_BINS];

  // |x| with -32768 saturated to 32767 so the result always fits 15 bits
  function automatic logic [14:0] abs_sat(input logic [15:0] v);
    if (!v[15])
      abs_sat = v[14:0];
    else if (v == 16'h8000)
      abs_sat = 15'h7FFF;
    else
      abs_sat = ~v[14:0] + 15'd1;
  endfunction

  logic [14:0] a_re, a_im, mx, mn;
  logic [15:0] mag, mag_shr;
  logic [8:0]  h_new;

  always_comb begin
    a_re    = abs_sat(sample[31:16]);
    a_im    = abs_sat(sample[15:0]);
    mx      = (a_re >= a_im) ? a_re : a_im;
    mn      = (a_re >= a_im) ? a_im : a_re;
    mag     = {1'b0, mx} + {2'b00, mn[14:1]};
    mag_shr = mag >> MAG_SHIFT;
    h_new   = (mag_shr > MAX_H16) ? MAX_H16[8:0] : mag_shr[8:0];
  end

  assign data_req   = (state == S_REQ);
  assign wr_over    = (state == S_DONE);
  assign sweep_busy = (state != S_IDLE);

  always_ff @(posedge lcd_clk) begin
    if (rst) begin
      state   <= S_IDLE;
      lat_cnt <= '0;
      bin_idx <= '0;
      sample  <= '0;
      for (int i = 0; i < N_BINS; i++) height[i] <= '0;
    end else begin
      case (state)
        S_IDLE: if (frame_start) begin
          bin_idx <= '0;
          state   <= S_REQ;
        end
        S_REQ: begin
          lat_cnt <= '0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          if (lat_cnt == LAT_LAST) begin
            sample <= fifo_rd_data;
            state  <= S_CALC;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        S_CALC: begin
          height[bin_idx] <= h_new;
          state           <= S_DONE;
        end
        S_DONE: begin
          if (bin_idx == LAST_BIN) begin
            bin_idx <= '0;
            state   <= S_IDLE;
          end else begin
            bin_idx <= bin_idx + 1'b1;
            state   <= S_REQ;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic [10:0] col;
  logic [8:0]  h_px;
  logic        is_bar;

  // Lit when Y_BASE-h < y <= Y_BASE, rearranged as y+h > Y_BASE to stay unsigned
  always_comb begin
    col    = pixel_xpos >> XSH;
    h_px   = (col < N_BINS11) ? height[col[BW-1:0]] : 9'd0;
    is_bar = ({1'b0, pixel_ypos} <= Y_BASE12) &&
             (({1'b0, pixel_ypos} + {3'b000, h_px}) > Y_BASE12);
  end

  always_ff @(posedge lcd_clk) begin
    if (rst) pixel_data <= BG_COLOR;
    else     pixel_data <= is_bar ? BAR_COLOR : BG_COLOR;
  end

endmodule
